// File: rtl/de0_wing_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : de0_wing_pkg                                              |
// | Purpose  : Shared types and constants for the DE0 digital I/O wing   |
// |            driver (port FSM states, direction and enable encodings,  |
// |            port width).                                              |
// | Ports    : none (package)                                            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package de0_wing_pkg;

  // Width of one wing port / transceiver bus
  localparam int PORT_W = 8;

  // Direction encoding, shared by the DIRx request and the IOx pin
  localparam logic DIR_OUT = 1'b1;  // FPGA -> connector
  localparam logic DIR_IN  = 1'b0;  // connector -> FPGA

  // Transceiver output enable is active-low
  localparam logic OE_ON  = 1'b0;
  localparam logic OE_OFF = 1'b1;

  // Per-port turnaround FSM
  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,  // transceiver disabled, DIR pin stable, waiting
    ST_ACTIVE = 2'd1,  // transceiver enabled in direction dir_cur
    ST_OFF    = 2'd2   // transceiver disabled, old DIR still applied
  } port_state_e;

endpackage : de0_wing_pkg
`default_nettype wire

// File: rtl/de0_wing_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : de0_wing_port                                             |
// | Purpose  : One bidirectional wing port: turnaround FSM, drive data   |
// |            register, tristate bus driver and read synchronizer.      |
// | Ports    : clk, rst_n  - clock, async active-low reset               |
// |            dir_i       - direction request (1 = FPGA drives)         |
// |            in_i        - data to drive when output                   |
// |            out_o       - synchronized bus read data                  |
// |            io_o        - transceiver DIR pin                         |
// |            oe_o        - transceiver output enable (active-low)      |
// |            bus_io      - FPGA-side transceiver bus                   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module de0_wing_port
  import de0_wing_pkg::*;
#(
  parameter int TURN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dir_i,
  input  logic [PORT_W-1:0] in_i,
  output logic [PORT_W-1:0] out_o,
  output logic              io_o,
  output logic              oe_o,
  inout  wire  [PORT_W-1:0] bus_io
);

  localparam int            CW       = $clog2(TURN_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TURN_CYCLES - 1);

  port_state_e       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              dir_cur_q, dir_cur_d;
  logic              dir_tgt_q, dir_tgt_d;
  logic [PORT_W-1:0] drv_q;
  logic [PORT_W-1:0] sync1_q, sync2_q;
  logic              drive_en;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_SETTLE;
      cnt_q     <= '0;
      dir_cur_q <= DIR_IN;
      dir_tgt_q <= DIR_IN;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_cur_q <= dir_cur_d;
      dir_tgt_q <= dir_tgt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_cur_d = dir_cur_q;
    dir_tgt_d = dir_tgt_q;
    oe_o      = OE_OFF;
    io_o      = dir_cur_q;
    drive_en  = 1'b0;

    case (state_q)
      ST_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_ACTIVE: begin
        oe_o     = OE_ON;
        drive_en = (dir_cur_q == DIR_OUT);
        // DIR is only sampled here; requests during a turnaround are
        // picked up again once the port is back in ACTIVE.
        if (dir_i != dir_cur_q) begin
          dir_tgt_d = dir_i;
          state_d   = ST_OFF;
          cnt_d     = '0;
        end
      end

      ST_OFF: begin
        // The DIR pin only moves on the exit edge of OFF, so it always
        // changes while the transceiver is disabled.
        if (cnt_q == CNT_LAST) begin
          dir_cur_d = dir_tgt_q;
          state_d   = ST_SETTLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end
    endcase
  end

  // -------------------------------------------------------- data paths
  // Drive data is re-registered every cycle regardless of state, so the
  // bus value trails in_i by exactly one clock when driving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drv_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      drv_q   <= in_i;
      sync1_q <= bus_io;
      sync2_q <= sync1_q;
    end
  end

  assign bus_io = drive_en ? drv_q : {PORT_W{1'bz}};

  // The second synchronizer stage is the read register itself, giving a
  // two-clock bus-to-output latency.
  assign out_o = sync2_q;

endmodule : de0_wing_port
`default_nettype wire

// File: rtl/de0_digital_io_wing.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : de0_digital_io_wing                                       |
// | Purpose  : Driver for the DE0 digital I/O wing: four independent     |
// |            8-bit bidirectional ports (A..D), each behind a bus       |
// |            transceiver, with guarded direction turnaround.           |
// | Ports    : clk, rst_n          - clock, async active-low reset       |
// |            DIRA..DIRD          - direction request per port          |
// |            INA..IND            - drive data per port                 |
// |            OUTA..OUTD          - synchronized read data per port     |
// |            IOA..IOD            - transceiver DIR pins                |
// |            OEA..OED            - transceiver enables (active-low)    |
// |            BUSA..BUSD          - FPGA-side transceiver buses         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module de0_digital_io_wing
  import de0_wing_pkg::*;
#(
  parameter int TURN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              DIRA,
  input  logic              DIRB,
  input  logic              DIRC,
  input  logic              DIRD,
  input  logic [PORT_W-1:0] INA,
  input  logic [PORT_W-1:0] INB,
  input  logic [PORT_W-1:0] INC,
  input  logic [PORT_W-1:0] IND,
  output logic [PORT_W-1:0] OUTA,
  output logic [PORT_W-1:0] OUTB,
  output logic [PORT_W-1:0] OUTC,
  output logic [PORT_W-1:0] OUTD,
  output logic              IOA,
  output logic              IOB,
  output logic              IOC,
  output logic              IOD,
  inout  wire  [PORT_W-1:0] BUSA,
  inout  wire  [PORT_W-1:0] BUSB,
  inout  wire  [PORT_W-1:0] BUSC,
  inout  wire  [PORT_W-1:0] BUSD,
  output logic              OEA,
  output logic              OEB,
  output logic              OEC,
  output logic              OED
);

  de0_wing_port #(.TURN_CYCLES(TURN_CYCLES)) u_port_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .dir_i  (DIRA),
    .in_i   (INA),
    .out_o  (OUTA),
    .io_o   (IOA),
    .oe_o   (OEA),
    .bus_io (BUSA)
  );

  de0_wing_port #(.TURN_CYCLES(TURN_CYCLES)) u_port_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .dir_i  (DIRB),
    .in_i   (INB),
    .out_o  (OUTB),
    .io_o   (IOB),
    .oe_o   (OEB),
    .bus_io (BUSB)
  );

  de0_wing_port #(.TURN_CYCLES(TURN_CYCLES)) u_port_c (
    .clk    (clk),
    .rst_n  (rst_n),
    .dir_i  (DIRC),
    .in_i   (INC),
    .out_o  (OUTC),
    .io_o   (IOC),
    .oe_o   (OEC),
    .bus_io (BUSC)
  );

  de0_wing_port #(.TURN_CYCLES(TURN_CYCLES)) u_port_d (
    .clk    (clk),
    .rst_n  (rst_n),
    .dir_i  (DIRD),
    .in_i   (IND),
    .out_o  (OUTD),
    .io_o   (IOD),
    .oe_o   (OED),
    .bus_io (BUSD)
  );

endmodule : de0_digital_io_wing
`default_nettype wire

// File: tb/tb_de0_digital_io_wing.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_de0_digital_io_wing                                    |
// | Purpose  : Scoreboard bench for de0_digital_io_wing. A timeline      |
// |            model of each port (turnaround time remaining, current    |
// |            and target direction, bus history) predicts every cycle's |
// |            OE/IO/BUS/OUT; a negedge monitor pops and compares.       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_de0_digital_io_wing;

  localparam int T = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] dir_v = '0;
  logic [7:0] in_v  [4];
  logic [3:0] ext_en = '0;
  logic [7:0] ext_v [4];

  wire [7:0] OUTA, OUTB, OUTC, OUTD;
  wire       IOA, IOB, IOC, IOD;
  wire       OEA, OEB, OEC, OED;
  wire [7:0] BUSA, BUSB, BUSC, BUSD;

  // External device side of each transceiver
  assign BUSA = ext_en[0] ? ext_v[0] : 8'hzz;
  assign BUSB = ext_en[1] ? ext_v[1] : 8'hzz;
  assign BUSC = ext_en[2] ? ext_v[2] : 8'hzz;
  assign BUSD = ext_en[3] ? ext_v[3] : 8'hzz;

  de0_digital_io_wing #(.TURN_CYCLES(T)) dut (
    .clk (clk), .rst_n (rst_n),
    .DIRA(dir_v[0]), .DIRB(dir_v[1]), .DIRC(dir_v[2]), .DIRD(dir_v[3]),
    .INA (in_v[0]), .INB (in_v[1]), .INC (in_v[2]), .IND (in_v[3]),
    .OUTA(OUTA), .OUTB(OUTB), .OUTC(OUTC), .OUTD(OUTD),
    .IOA (IOA), .IOB (IOB), .IOC (IOC), .IOD (IOD),
    .BUSA(BUSA), .BUSB(BUSB), .BUSC(BUSC), .BUSD(BUSD),
    .OEA (OEA), .OEB (OEB), .OEC (OEC), .OED (OED)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------------ accessors
  function automatic logic get_oe(input int p);
    case (p) 0: return OEA; 1: return OEB; 2: return OEC; default: return OED; endcase
  endfunction
  function automatic logic get_io(input int p);
    case (p) 0: return IOA; 1: return IOB; 2: return IOC; default: return IOD; endcase
  endfunction
  function automatic logic [7:0] get_out(input int p);
    case (p) 0: return OUTA; 1: return OUTB; 2: return OUTC; default: return OUTD; endcase
  endfunction
  function automatic logic [7:0] get_bus(input int p);
    case (p) 0: return BUSA; 1: return BUSB; 2: return BUSC; default: return BUSD; endcase
  endfunction

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string nm, input int p, input int cy,
                              input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s port %0d cycle %0d got %h expected %h", nm, p, cy, act, req);
    end
  endfunction

  // ------------------------------------------------------ reference model
  // m_ta = clocks of turnaround still to go: > T means OFF, 1..T SETTLE,
  // 0 ACTIVE. Bus history m_bh1/m_bh2 hold the bus one/two cycles back.
  bit         m_cur [4];
  bit         m_tgt [4];
  int         m_ta  [4];
  logic [7:0] m_drv [4];
  logic [7:0] m_bus [4];
  logic [7:0] m_bh1 [4];
  logic [7:0] m_bh2 [4];
  bit         revert [4];
  int         phase = 0;
  int         cyc   = 0;
  bit         d_dir = 1'b0;

  typedef struct {
    int         port;
    int         cyc;
    logic       oe;
    logic       io;
    logic [7:0] bus;
    logic [7:0] out;
  } exp_t;
  exp_t sb[$];

  function automatic void model_reset();
    for (int p = 0; p < 4; p++) begin
      m_cur[p] = 1'b0; m_tgt[p] = 1'b0; m_ta[p] = T;
      m_drv[p] = 8'h00; m_bh1[p] = 8'h00; m_bh2[p] = 8'h00;
    end
  endfunction

  // Advance the model across one rising edge using the inputs held there.
  function automatic void model_edge();
    for (int p = 0; p < 4; p++) begin
      m_bh2[p] = m_bh1[p];
      m_bh1[p] = m_bus[p];
      m_drv[p] = in_v[p];
      if (m_ta[p] == 0) begin
        if (dir_v[p] != m_cur[p]) begin
          m_tgt[p] = dir_v[p];
          m_ta[p]  = 2 * T;
        end
      end else begin
        if (m_ta[p] == T + 1) m_cur[p] = m_tgt[p];
        m_ta[p]--;
      end
    end
  endfunction

  function automatic logic [7:0] pick_ext(input int p);
    if (phase == 1 && p == 1 && cyc == 30) return 8'h5A;
    if (phase == 1 && p == 1 && cyc == 31) return 8'hA5;
    return 8'($urandom);
  endfunction

  function automatic void pick_inputs();
    for (int p = 0; p < 4; p++) in_v[p] = 8'($urandom);
    case (phase)
      0: dir_v = 4'b0000;
      1: begin
        dir_v[0] = 1'b1;
        dir_v[1] = 1'b0;
        dir_v[2] = (cyc != 20);
        dir_v[3] = (cyc >= 40 && cyc < 60);
        in_v[0]  = 8'(cyc);
      end
      default: begin
        for (int p = 0; p < 4; p++) begin
          if (revert[p]) begin
            dir_v[p] = ~dir_v[p];
            revert[p] = 1'b0;
          end else begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r < 2) dir_v[p] = ~dir_v[p];
            else if (r == 2) begin
              dir_v[p] = ~dir_v[p];
              revert[p] = 1'b1;
            end
          end
        end
        if (phase == 3) begin
          revert[3] = 1'b0;
          dir_v[3]  = d_dir;
          in_v[3]   = 8'hC3;
        end
      end
    endcase
  endfunction

  // Set up the cycle that has just begun: bus ownership, expectations,
  // then the inputs that the next rising edge will sample.
  function automatic void cycle_setup();
    for (int p = 0; p < 4; p++) begin
      exp_t e;
      if (m_ta[p] == 0 && m_cur[p]) begin
        ext_en[p] = 1'b0;
        m_bus[p]  = m_drv[p];
      end else begin
        ext_en[p] = 1'b1;
        ext_v[p]  = pick_ext(p);
        m_bus[p]  = ext_v[p];
      end
      e.port = p;
      e.cyc  = cyc;
      e.oe   = (m_ta[p] != 0);
      e.io   = m_cur[p];
      e.bus  = m_bus[p];
      e.out  = m_bh2[p];
      sb.push_back(e);
    end
    pick_inputs();
  endfunction

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      model_edge();
      cyc++;
      cycle_setup();
    end
  endtask

  task automatic reset_release();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cyc = 1;
    cycle_setup();
  endtask

  // -------------------------------------------------------------- monitor
  exp_t mon_e;
  logic last_io [4];
  logic last_oe [4];
  initial for (int p = 0; p < 4; p++) begin last_io[p] = 1'b0; last_oe[p] = 1'b1; end

  always @(negedge clk) begin
    while (sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk("OE",  mon_e.port, mon_e.cyc, {7'b0, get_oe(mon_e.port)}, {7'b0, mon_e.oe});
      chk("IO",  mon_e.port, mon_e.cyc, {7'b0, get_io(mon_e.port)}, {7'b0, mon_e.io});
      chk("BUS", mon_e.port, mon_e.cyc, get_bus(mon_e.port), mon_e.bus);
      chk("OUT", mon_e.port, mon_e.cyc, get_out(mon_e.port), mon_e.out);
    end
    // The DIR pin may only move while the transceiver is disabled.
    for (int p = 0; p < 4; p++) begin
      if (get_io(p) !== last_io[p])
        chk("OE_AT_IO_TOGGLE", p, cyc, {7'b0, get_oe(p) & last_oe[p]}, 8'h01);
      last_io[p] = get_io(p);
      last_oe[p] = get_oe(p);
    end
  end

  // ----------------------------------------------------------- stimulus
  initial begin
    for (int p = 0; p < 4; p++) begin
      in_v[p] = 8'h00; ext_v[p] = 8'h00; revert[p] = 1'b0;
    end

    phase = 0;               // all ports input after reset
    reset_release();
    run(12);

    phase = 1;               // directed: A output counting, B input, C pulse, D staggered
    reset_release();
    run(300);

    phase = 2;               // randomized direction changes and pulses
    run(800);

    phase = 3;               // bring D to output, then start turning it around
    d_dir = 1'b1;
    begin
      int n;
      n = 0;
      while (!(m_ta[3] == 0 && m_cur[3]) && n < 60) begin
        run(1);
        n++;
      end
      if (n >= 60) begin
        checks++;
        errors++;
        $display("FAIL D_REACH_OUTPUT port 3 cycle %0d got timeout expected active output", cyc);
      end
    end
    run(4);
    d_dir = 1'b0;
    run(2);                  // second edge detects the mismatch -> OFF

    // Mid-cycle asynchronous reset while D is in OFF with IOD still 1.
    #5;
    chk("D_PRE_IO", 3, cyc, {7'b0, IOD}, 8'h01);
    chk("D_PRE_OE", 3, cyc, {7'b0, OED}, 8'h01);
    rst_n = 1'b0;
    #1;
    for (int p = 0; p < 4; p++) begin
      chk("RST_OE",  p, cyc, {7'b0, get_oe(p)}, 8'h01);
      chk("RST_IO",  p, cyc, {7'b0, get_io(p)}, 8'h00);
      chk("RST_OUT", p, cyc, get_out(p), 8'h00);
    end
    chk("RST_BUS", 3, cyc, BUSD, ext_v[3]);
    sb.delete();

    phase = 2;
    reset_release();
    run(40);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog port 0 cycle %0d got timeout expected finish", cyc);
    $fatal(1, "simulation time limit");
  end

endmodule : tb_de0_digital_io_wing
`default_nettype wire

// File: doc/de0_digital_io_wing.md
Name: de0_digital_io_wing

Overview:
- Driver for the DE0 digital I/O wing: four independent 8-bit bidirectional ports, A to D, each behind an external 8-bit bus transceiver.
- Each transceiver has a DIR pin (IOx) and an active-low output enable (OEx).
- The block converts a simple per-port direction request plus in/out data buses into safe transceiver control and tristate bus handling, so the FPGA and transceiver never drive the same bus together.
- It sits between user logic and the wing connector pins.

Parameters:
- TURN_CYCLES, 2: guard length in clocks for each turnaround phase (OFF and SETTLE). Legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- DIRA, DIRB, DIRC, DIRD  in  1 each  direction request: 1 = FPGA drives the port (output), 0 = port is input.
- INA, INB, INC, IND  in  8 each  data to drive onto the port when it is an output.
- OUTA, OUTB, OUTC, OUTD  out  8 each  synchronized data read from the port bus.
- IOA, IOB, IOC, IOD  out  1 each  transceiver DIR pin: 1 = FPGA to connector, 0 = connector to FPGA.
- BUSA, BUSB, BUSC, BUSD  inout  8 each  FPGA-side transceiver bus.
- OEA, OEB, OEC, OED  out  1 each  transceiver output enable, active-low (0 = enabled).

Behaviour:
The four ports are identical and fully independent. Each port has a 3-state FSM (SETTLE, ACTIVE, OFF), a registered current direction dir_cur, a target direction dir_tgt and a guard counter.

Reset (rst_n = 0, asynchronous) puts every port in this state:
- dir_cur = 0 and dir_tgt = 0.
- State SETTLE, counter = 0.
- OEx = 1 and IOx = 0.
- BUSx = Z.
- OUTx = 0, and both synchronizer stages = 0.
- The drive data register = 0.

SETTLE:
- OEx = 1, IOx = dir_cur, BUSx = Z.
- Lasts exactly TURN_CYCLES cycles, then goes to ACTIVE.

ACTIVE:
- OEx = 0, IOx = dir_cur.
- If dir_cur = 1, BUSx = drive register; otherwise BUSx = Z.
- On any rising edge where DIRx != dir_cur: set dir_tgt <= DIRx and go to OFF. OEx = 1 from the next cycle.

OFF:
- OEx = 1, IOx = dir_cur (old value), BUSx = Z.
- Lasts exactly TURN_CYCLES cycles.
- On exit, dir_cur <= dir_tgt and the state goes to SETTLE, so IOx changes only while the transceiver is disabled.

Turnaround rules:
- DIRx is ignored during OFF and SETTLE. A request that reverts mid-turnaround completes the current turnaround; the mismatch is then re-evaluated in the first ACTIVE cycle.
- A 1-cycle DIRx pulse seen in ACTIVE triggers a full turnaround, and the port then returns if the request has reverted.
- Minimum turnaround: ACTIVE with the new direction begins 2*TURN_CYCLES+1 cycles after the detecting edge. The detecting edge ends the last old-ACTIVE cycle.

Data paths:
- Drive register <= INx every cycle, unconditionally. The bus value lags INx by one clock.
- Read path: BUSx passes through a 2-flop synchronizer, then OUTx <= stage2. Latency is 2 clocks from BUSx to OUTx.
- The read path is active in all states. While the port is an output, OUTx reflects the driven value (loopback). While Z with no external driver, the value is don't-care.

General:
- No arithmetic.
- The counter is ceil(log2(TURN_CYCLES+1)) bits, cleared on every state entry.

Decomposition:
- Shared package de0_wing_pkg holds:
  - the state enum (SETTLE, ACTIVE, OFF);
  - constants DIR_OUT = 1 and DIR_IN = 0;
  - OE_ON = 0 and OE_OFF = 1;
  - PORT_W = 8.
- One sub-module, de0_wing_port, implements a single port (FSM, drive register, synchronizer, tristate). The top instantiates it four times.

Test Plan:
- Reset then release with all DIRx = 0: OEx = 1 for cycles 1–2, OEx = 0 from cycle 3; IOx = 0 and BUSx = Z throughout.
- From reset with DIRA = 1 held: cycle 3 ACTIVE with IOA = 0; cycles 4–5 OEA = 1, IOA = 0; cycles 6–7 OEA = 1, IOA = 1, BUSA = Z; cycle 8 OEA = 0 and BUSA drives INA.
- Output mode, INA counting 0x00..0xFF each cycle: BUSA equals INA delayed 1 clock; OUTA equals BUSA delayed 2 clocks, with wrap 0xFF to 0x00 seen intact.
- Input mode, external driver puts 0x5A then 0xA5 on BUSB: OUTB = 0x5A two clocks after the first value, then 0xA5; BUSB is never driven by the FPGA.
- 1-cycle DIRC low pulse while ACTIVE as output: OEC rises; the port goes OFF (2) → SETTLE (2, IOC = 0) → ACTIVE (1 cycle, mismatch) → OFF → SETTLE (IOC = 1) → ACTIVE output. OEC = 0 is never seen while IOC toggles.
- rst_n asserted mid-OFF on port D: OED = 1, IOD = 0, BUSD = Z and OUTD = 0 immediately, without waiting for a clock edge; ports A–C are independently verified unaffected in a non-reset run with staggered DIR changes.
